// File: rtl/bcd_calc_core_if.sv
// ---------------------------------------------------------------------------
// bcd_calc_core_if
// Bundle between the keypad entry stage / scan stage and bcd_calc_core.
//   start      request pulse (sampled only while the core is idle)
//   op         0=add, 1=sub, 2=mul, 3=reserved
//   dig0..dig3 entry digits: dig3:dig2 = operand A, dig1:dig0 = operand B
//   res0..res3 result digits, ones .. thousands, leading zeros blanked
//   neg        result magnitude is shown, this flags a negative result
//   err        bad operand digit or reserved op
//   busy       core is not idle
//   done       one-cycle pulse when res*/neg/err update
// master: the side issuing requests; slave: the calculator core.
// ---------------------------------------------------------------------------
interface bcd_calc_core_if;
  logic       start;
  logic [1:0] op;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] res0;
  logic [3:0] res1;
  logic [3:0] res2;
  logic [3:0] res3;
  logic       neg;
  logic       err;
  logic       busy;
  logic       done;

  modport master (
    output start, op, dig0, dig1, dig2, dig3,
    input  res0, res1, res2, res3, neg, err, busy, done
  );

  modport slave (
    input  start, op, dig0, dig1, dig2, dig3,
    output res0, res1, res2, res3, neg, err, busy, done
  );
endinterface

// File: rtl/bcd_calc_core.sv
// ---------------------------------------------------------------------------
// bcd_calc_core
// Two-digit BCD calculator behind the keypad entry register. On start it
// snapshots A (dig3:dig2), B (dig1:dig0) and op, converts to binary, runs
// add / sub (one cycle) or a 7-step shift-add multiply, converts the result
// back to BCD with a 14-step double-dabble and presents it with
// leading-zero blanking.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bcd_calc_core_if.slave (start/op/dig* in, res*/neg/err/busy/done out)
// ---------------------------------------------------------------------------
module bcd_calc_core #(
  parameter logic [3:0] BCD_NULL  = 4'd13,
  parameter int         CONV_BITS = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_calc_core_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALU,
    MUL,
    CONV,
    DONE
  } state_t;

  state_t state_reg, state_next;

  // Snapshot of the request
  logic [3:0][3:0]      dig_reg;
  logic [1:0]           op_reg;

  // Datapath
  logic [6:0]           a_reg;
  logic [6:0]           b_reg;
  logic                 err_pend_reg;
  logic                 neg_pend_reg;
  logic [CONV_BITS-1:0] acc_reg;
  logic [3:0]           cnt_reg;
  logic [15:0]          dd_bcd_reg;
  logic [CONV_BITS-1:0] dd_bin_reg;

  // Presented result
  logic [3:0][3:0]      res_reg;
  logic                 neg_reg;
  logic                 err_reg;
  logic                 done_reg;

  // -------------------------------------------------------------------------
  // Operand decode from the snapshot
  // -------------------------------------------------------------------------
  logic [3:0][3:0] dig_val;
  logic [3:0]      dig_bad;
  logic [6:0]      a_dec;
  logic [6:0]      b_dec;
  logic            load_err;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig
      // A blank digit reads as zero; any other non-decimal code is an error.
      assign dig_val[gi] = (dig_reg[gi] == BCD_NULL) ? 4'd0 : dig_reg[gi];
      assign dig_bad[gi] = (dig_reg[gi] > 4'd9) && (dig_reg[gi] != BCD_NULL);
    end
  endgenerate

  assign a_dec    = {3'd0, dig_val[3]} * 7'd10 + {3'd0, dig_val[2]};
  assign b_dec    = {3'd0, dig_val[1]} * 7'd10 + {3'd0, dig_val[0]};
  assign load_err = (|dig_bad) || (op_reg == 2'd3);

  // -------------------------------------------------------------------------
  // Add / subtract
  // -------------------------------------------------------------------------
  logic [7:0]           sum_val;
  logic                 a_ge_b;
  logic [6:0]           mag_val;
  logic [CONV_BITS-1:0] alu_r;

  assign sum_val = {1'b0, a_reg} + {1'b0, b_reg};
  assign a_ge_b  = (a_reg >= b_reg);
  assign mag_val = a_ge_b ? (a_reg - b_reg) : (b_reg - a_reg);
  assign alu_r   = (op_reg == 2'd0) ? CONV_BITS'(sum_val) : CONV_BITS'(mag_val);

  // -------------------------------------------------------------------------
  // Shift-add multiplier step: bit cnt_reg of B selects A << cnt_reg
  // -------------------------------------------------------------------------
  logic [CONV_BITS-1:0] a_shift;
  logic [CONV_BITS-1:0] acc_next;

  assign a_shift  = {{(CONV_BITS-7){1'b0}}, a_reg} << cnt_reg[2:0];
  assign acc_next = b_reg[cnt_reg[2:0]] ? (acc_reg + a_shift) : acc_reg;

  // -------------------------------------------------------------------------
  // Double-dabble step: correct nibbles >= 5, then shift the whole
  // {bcd, bin} pair left by one so the next binary MSB enters the BCD ones.
  // -------------------------------------------------------------------------
  logic [15:0]           dd_adj;
  logic [CONV_BITS+15:0] dd_shift;
  logic [15:0]           dd_bcd_next;
  logic [CONV_BITS-1:0]  dd_bin_next;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign dd_adj[gi*4 +: 4] = (dd_bcd_reg[gi*4 +: 4] >= 4'd5)
                               ? (dd_bcd_reg[gi*4 +: 4] + 4'd3)
                               : dd_bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign dd_shift    = {dd_adj, dd_bin_reg} << 1;
  assign dd_bcd_next = dd_shift[CONV_BITS+15:CONV_BITS];
  assign dd_bin_next = dd_shift[CONV_BITS-1:0];

  // -------------------------------------------------------------------------
  // Leading-zero blanking of the converted value (ones digit always shown)
  // -------------------------------------------------------------------------
  logic            lz3;
  logic            lz2;
  logic            lz1;
  logic [3:0][3:0] res_disp;

  assign lz3 = (dd_bcd_reg[15:12] == 4'd0);
  assign lz2 = lz3 && (dd_bcd_reg[11:8] == 4'd0);
  assign lz1 = lz2 && (dd_bcd_reg[7:4] == 4'd0);

  assign res_disp[3] = lz3 ? BCD_NULL : dd_bcd_reg[15:12];
  assign res_disp[2] = lz2 ? BCD_NULL : dd_bcd_reg[11:8];
  assign res_disp[1] = lz1 ? BCD_NULL : dd_bcd_reg[7:4];
  assign res_disp[0] = dd_bcd_reg[3:0];

  // A start coinciding with the done pulse belongs to the finished
  // operation's handshake and is not taken as a new request.
  logic start_ok;
  assign start_ok = bus.start && !done_reg;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (load_err) begin
          state_next = DONE;
        end else if (op_reg == 2'd2) begin
          state_next = MUL;
        end else begin
          state_next = ALU;
        end
      end
      ALU: begin
        state_next = CONV;
      end
      MUL: begin
        if (cnt_reg == 4'd6) begin
          state_next = CONV;
        end
      end
      CONV: begin
        if (cnt_reg == 4'(CONV_BITS - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_reg      <= '0;
      op_reg       <= 2'd0;
      a_reg        <= 7'd0;
      b_reg        <= 7'd0;
      err_pend_reg <= 1'b0;
      neg_pend_reg <= 1'b0;
      acc_reg      <= '0;
      cnt_reg      <= 4'd0;
      dd_bcd_reg   <= 16'd0;
      dd_bin_reg   <= '0;
      res_reg      <= {4{BCD_NULL}};
      neg_reg      <= 1'b0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            dig_reg <= {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
            op_reg  <= bus.op;
          end
        end
        LOAD: begin
          a_reg        <= a_dec;
          b_reg        <= b_dec;
          err_pend_reg <= load_err;
          neg_pend_reg <= 1'b0;
          acc_reg      <= '0;
          cnt_reg      <= 4'd0;
        end
        ALU: begin
          dd_bin_reg   <= alu_r;
          dd_bcd_reg   <= 16'd0;
          neg_pend_reg <= (op_reg == 2'd1) && !a_ge_b;
          cnt_reg      <= 4'd0;
        end
        MUL: begin
          acc_reg <= acc_next;
          if (cnt_reg == 4'd6) begin
            // Last partial product goes straight into the converter.
            dd_bin_reg <= acc_next;
            dd_bcd_reg <= 16'd0;
            cnt_reg    <= 4'd0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        CONV: begin
          dd_bcd_reg <= dd_bcd_next;
          dd_bin_reg <= dd_bin_next;
          cnt_reg    <= cnt_reg + 4'd1;
        end
        DONE: begin
          if (err_pend_reg) begin
            res_reg <= {4{BCD_NULL}};
            neg_reg <= 1'b0;
            err_reg <= 1'b1;
          end else begin
            res_reg <= res_disp;
            neg_reg <= neg_pend_reg;
            err_reg <= 1'b0;
          end
          done_reg <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.res0 = res_reg[0];
  assign bus.res1 = res_reg[1];
  assign bus.res2 = res_reg[2];
  assign bus.res3 = res_reg[3];
  assign bus.neg  = neg_reg;
  assign bus.err  = err_reg;
  assign bus.done = done_reg;
  assign bus.busy = (state_reg != IDLE);

endmodule
